alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared ALU. Each requester presents an opcode/operand pair with a request. The block grants one requester, latches its command into the registers that drive the ALU, and waits a configurable number of cycles for the ALU to settle. It then captures the result and returns it to the granted requester with a one-cycle done pulse. It sits between the UART command front end (requester 0), a second command source (requester 1) and the single combinational ALU.

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared combinational ALU.
// Grants one command, holds it on the ALU for ALU_LATENCY cycles, then returns the result.
module alu_arbiter #(
  parameter int NB_DATA     = 8,
  parameter int NB_OPCODE   = 6,
  parameter int ALU_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req0,
  input  logic                 i_req1,
  input  logic [NB_OPCODE-1:0] i_opcode0,
  input  logic [NB_OPCODE-1:0] i_opcode1,
  input  logic [NB_DATA-1:0]   i_op_a0,
  input  logic [NB_DATA-1:0]   i_op_a1,
  input  logic [NB_DATA-1:0]   i_op_b0,
  input  logic [NB_DATA-1:0]   i_op_b1,
  output logic                 o_gnt0,
  output logic                 o_gnt1,
  output logic                 o_done0,
  output logic                 o_done1,
  output logic [NB_DATA-1:0]   o_result,
  output logic [NB_OPCODE-1:0] o_alu_opcode,
  output logic [NB_DATA-1:0]   o_alu_op_A,
  output logic [NB_DATA-1:0]   o_alu_op_B,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic                 o_busy,
  output logic                 o_last_grant
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

  state_t               state;
  state_t               state_next;
  logic [3:0]           cnt;
  logic [3:0]           cnt_next;
  logic                 gnt0_next;
  logic                 gnt1_next;
  logic                 done0_next;
  logic                 done1_next;
  logic [NB_DATA-1:0]   result_next;
  logic [NB_OPCODE-1:0] opcode_next;
  logic [NB_DATA-1:0]   op_a_next;
  logic [NB_DATA-1:0]   op_b_next;
  logic                 last_next;
  logic                 busy_next;
  logic                 any_req;
  logic                 winner;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    any_req = i_req0 | i_req1;
    winner  = 1'b0;
    if (i_req0 && i_req1) begin
      winner = ~o_last_grant;
    end else begin
      winner = i_req1;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    gnt0_next   = 1'b0;
    gnt1_next   = 1'b0;
    done0_next  = 1'b0;
    done1_next  = 1'b0;
    result_next = o_result;
    opcode_next = o_alu_opcode;
    op_a_next   = o_alu_op_A;
    op_b_next   = o_alu_op_B;
    last_next   = o_last_grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          opcode_next = winner ? i_opcode1 : i_opcode0;
          op_a_next   = winner ? i_op_a1 : i_op_a0;
          op_b_next   = winner ? i_op_b1 : i_op_b0;
          gnt0_next   = ~winner;
          gnt1_next   = winner;
          last_next   = winner;
          cnt_next    = CNT_LOAD;
          state_next  = EXEC;
        end
      end
      EXEC: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          // o_last_grant still names the requester that owns this operation.
          result_next = i_alu_result;
          done0_next  = ~o_last_grant;
          done1_next  = o_last_grant;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      o_gnt0       <= 1'b0;
      o_gnt1       <= 1'b0;
      o_done0      <= 1'b0;
      o_done1      <= 1'b0;
      o_result     <= '0;
      o_alu_opcode <= '0;
      o_alu_op_A   <= '0;
      o_alu_op_B   <= '0;
      o_last_grant <= 1'b1;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      o_gnt0       <= gnt0_next;
      o_gnt1       <= gnt1_next;
      o_done0      <= done0_next;
      o_done1      <= done1_next;
      o_result     <= result_next;
      o_alu_opcode <= opcode_next;
      o_alu_op_A   <= op_a_next;
      o_alu_op_B   <= op_b_next;
      o_last_grant <= last_next;
      o_busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: three instances at ALU_LATENCY 1, 4 and 2.
// Stimulus pushes expected grant/done events; the negedge monitor pops and compares.
module tb_alu_arbiter;

  localparam int N = 3;

  typedef struct packed {
    logic        who;
    logic [31:0] cyc;
    logic [7:0]  val;
  } exp_t;

  logic       clk;
  logic       rst      [N];
  logic       req0     [N];
  logic       req1     [N];
  logic [5:0] opc0     [N];
  logic [5:0] opc1     [N];
  logic [7:0] a0       [N];
  logic [7:0] a1       [N];
  logic [7:0] b0       [N];
  logic [7:0] b1       [N];
  logic       gnt0     [N];
  logic       gnt1     [N];
  logic       done0    [N];
  logic       done1    [N];
  logic [7:0] result   [N];
  logic [5:0] aopc     [N];
  logic [7:0] aa       [N];
  logic [7:0] ab       [N];
  logic [7:0] alu_res  [N];
  logic       busy     [N];
  logic       last     [N];
  logic       hold_en  [N];
  logic [5:0] hold_opc [N];
  logic [7:0] hold_a   [N];
  logic [7:0] hold_b   [N];
  logic       end_req;

  int cyc       = 0;
  int check_cnt = 0;
  int pass_cnt  = 0;

  exp_t gnt_q  [N][$];
  exp_t done_q [N][$];

  function automatic logic [7:0] alu_model(input logic [5:0] opc, input logic [7:0] a, input logic [7:0] b);
    case (opc)
      6'h20:   return a + b;
      6'h22:   return a - b;
      default: return 8'h00;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    alu_arbiter #(
      .NB_DATA(8),
      .NB_OPCODE(6),
      .ALU_LATENCY(g == 0 ? 1 : (g == 1 ? 4 : 2))
    ) u_dut (
      .i_clk(clk),
      .i_reset(rst[g]),
      .i_req0(req0[g]),
      .i_req1(req1[g]),
      .i_opcode0(opc0[g]),
      .i_opcode1(opc1[g]),
      .i_op_a0(a0[g]),
      .i_op_a1(a1[g]),
      .i_op_b0(b0[g]),
      .i_op_b1(b1[g]),
      .o_gnt0(gnt0[g]),
      .o_gnt1(gnt1[g]),
      .o_done0(done0[g]),
      .o_done1(done1[g]),
      .o_result(result[g]),
      .o_alu_opcode(aopc[g]),
      .o_alu_op_A(aa[g]),
      .o_alu_op_B(ab[g]),
      .i_alu_result(alu_res[g]),
      .o_busy(busy[g]),
      .o_last_grant(last[g])
    );
    assign alu_res[g] = alu_model(aopc[g], aa[g], ab[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int g, input logic [63:0] act, input logic [63:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s dut%0d cycle %0d: got %0h, required %0h", name, g, cyc, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input int g, input logic who, input logic req,
                                input logic [5:0] opc, input logic [7:0] a, input logic [7:0] b);
    if (!who) begin
      req0[g] = req; opc0[g] = opc; a0[g] = a; b0[g] = b;
    end else begin
      req1[g] = req; opc1[g] = opc; a1[g] = a; b1[g] = b;
    end
  endtask

  task automatic expect_gnt(input int g, input logic who, input int at, input logic [7:0] op_a);
    gnt_q[g].push_back('{who: who, cyc: 32'(at), val: op_a});
  endtask

  task automatic expect_done(input int g, input logic who, input int at, input logic [7:0] res);
    done_q[g].push_back('{who: who, cyc: 32'(at), val: res});
  endtask

  // Monitor: every grant/done the DUT shows must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < N; g++) begin
      if (rst[g])
        check_output("reset_state", g,
                     {busy[g], gnt0[g], gnt1[g], done0[g], done1[g], last[g], result[g], aopc[g], aa[g], ab[g]},
                     {5'b0, 1'b1, 8'h00, 6'h00, 8'h00, 8'h00});
      if (gnt0[g] || gnt1[g]) begin
        check_output("gnt_exclusive", g, 64'(gnt0[g] & gnt1[g]), 64'd0);
        if (gnt_q[g].size() == 0) begin
          check_cnt++;
          $display("[TB] FAIL gnt_unexpected dut%0d: got grant at cycle %0d, required none", g, cyc);
        end else begin
          e = gnt_q[g].pop_front();
          check_output("gnt_who", g, 64'(gnt1[g]), 64'(e.who));
          check_output("gnt_cycle", g, 64'(cyc), 64'(e.cyc));
          check_output("gnt_op_a", g, 64'(aa[g]), 64'(e.val));
          check_output("last_grant", g, 64'(last[g]), 64'(e.who));
          check_output("busy_at_gnt", g, 64'(busy[g]), 64'd1);
        end
      end
      if (done0[g] || done1[g]) begin
        check_output("done_exclusive", g, 64'(done0[g] & done1[g]), 64'd0);
        if (done_q[g].size() == 0) begin
          check_cnt++;
          $display("[TB] FAIL done_unexpected dut%0d: got done at cycle %0d, required none", g, cyc);
        end else begin
          e = done_q[g].pop_front();
          check_output("done_who", g, 64'(done1[g]), 64'(e.who));
          check_output("done_cycle", g, 64'(cyc), 64'(e.cyc));
          check_output("done_result", g, 64'(result[g]), 64'(e.val));
        end
      end
      if (hold_en[g])
        check_output("alu_hold", g, {aopc[g], aa[g], ab[g]}, {hold_opc[g], hold_a[g], hold_b[g]});
    end
    if (end_req) begin
      for (int g = 0; g < N; g++) begin
        check_output("pending_gnt", g, 64'(gnt_q[g].size()), 64'd0);
        check_output("pending_done", g, 64'(done_q[g].size()), 64'd0);
      end
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
    end else if (cyc > 1000) begin
      check_cnt++;
      $display("[TB] FAIL timeout: got cycle %0d, required end of stimulus", cyc);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
    end
  end

  initial begin
    int c;
    for (int g = 0; g < N; g++) begin
      rst[g]  = 1'b1;
      apply_stimulus(g, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00);
      apply_stimulus(g, 1'b1, 1'b0, 6'h00, 8'h00, 8'h00);
      hold_en[g] = 1'b0; hold_opc[g] = 6'h00; hold_a[g] = 8'h00; hold_b[g] = 8'h00;
    end
    end_req = 1'b0;
    tick();
    tick();
    for (int g = 0; g < N; g++) rst[g] = 1'b0;
    tick();

    // dut0 (latency 1): single request from requester 0
    tick(); c = cyc;
    apply_stimulus(0, 1'b0, 1'b1, 6'h20, 8'h05, 8'h03);
    expect_gnt(0, 1'b0, c + 1, 8'h05);
    expect_done(0, 1'b0, c + 2, 8'h08);
    tick(); req0[0] = 1'b0;
    repeat (3) tick();

    // dut0: reset so the tie goes to requester 0
    rst[0] = 1'b1; tick(); rst[0] = 1'b0; tick();
    c = cyc;
    apply_stimulus(0, 1'b0, 1'b1, 6'h20, 8'h10, 8'h01);
    apply_stimulus(0, 1'b1, 1'b1, 6'h22, 8'h10, 8'h01);
    expect_gnt(0, 1'b0, c + 1, 8'h10);
    expect_done(0, 1'b0, c + 2, 8'h11);
    expect_gnt(0, 1'b1, c + 4, 8'h10);
    expect_done(0, 1'b1, c + 5, 8'h0F);
    tick(); req0[0] = 1'b0;
    repeat (3) tick(); req1[0] = 1'b0;
    repeat (3) tick();

    // dut0: both held for six commands, grants alternate starting with 0
    tick(); c = cyc;
    apply_stimulus(0, 1'b0, 1'b1, 6'h20, 8'h01, 8'h02);
    apply_stimulus(0, 1'b1, 1'b1, 6'h22, 8'h09, 8'h04);
    for (int k = 0; k < 6; k++) begin
      expect_gnt(0, k[0], c + 1 + 3 * k, k[0] ? 8'h09 : 8'h01);
      expect_done(0, k[0], c + 2 + 3 * k, k[0] ? 8'h05 : 8'h03);
    end
    repeat (16) tick();
    req0[0] = 1'b0; req1[0] = 1'b0;
    repeat (4) tick();

    // dut1 (latency 4): requester 1 alone, result wraps, request dropped after grant
    tick(); c = cyc;
    apply_stimulus(1, 1'b1, 1'b1, 6'h20, 8'hFF, 8'h02);
    expect_gnt(1, 1'b1, c + 1, 8'hFF);
    expect_done(1, 1'b1, c + 5, 8'h01);
    tick();
    hold_opc[1] = 6'h20; hold_a[1] = 8'hFF; hold_b[1] = 8'h02; hold_en[1] = 1'b1;
    tick();
    apply_stimulus(1, 1'b1, 1'b0, 6'h22, 8'h55, 8'h55);
    repeat (3) tick();
    hold_en[1] = 1'b0;
    repeat (2) tick();

    // dut1: reset in cycle 2 of an operation, no done may follow
    tick(); c = cyc;
    apply_stimulus(1, 1'b0, 1'b1, 6'h22, 8'h20, 8'h01);
    expect_gnt(1, 1'b0, c + 1, 8'h20);
    tick(); req0[1] = 1'b0;
    tick(); rst[1] = 1'b1;
    tick(); rst[1] = 1'b0;
    repeat (6) tick();

    // dut2 (latency 2): operand A changes after grant
    tick(); c = cyc;
    apply_stimulus(2, 1'b0, 1'b1, 6'h20, 8'h30, 8'h05);
    expect_gnt(2, 1'b0, c + 1, 8'h30);
    expect_done(2, 1'b0, c + 3, 8'h35);
    tick();
    tick();
    a0[2] = 8'hAA;
    hold_opc[2] = 6'h20; hold_a[2] = 8'h30; hold_b[2] = 8'h05; hold_en[2] = 1'b1;
    tick(); req0[2] = 1'b0;
    tick(); hold_en[2] = 1'b0;
    repeat (2) tick();

    end_req = 1'b1;
  end

endmodule
